// File: rtl/enc_4b5b_tx.sv
// 4b5b serial transmitter: one byte per frame as start bit, two 5-bit symbols (LSB first), stop bit.
// Define ENC_4B5B_TX_STOP2_EN to append a second stop bit (13 line bits per frame).
module enc_4b5b_tx #(
    parameter int BIT_CYCLES = 45
) (
    input  logic       CLK_50M,
    input  logic       RST,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       TXD,
    output logic       busy,
    output logic       frame_done
);

`ifdef ENC_4B5B_TX_STOP2_EN
    localparam int STOP_CYCLES = 2 * BIT_CYCLES;
`else
    localparam int STOP_CYCLES = BIT_CYCLES;
`endif

    // The counter is sized for the longest state, which is STOP when two stop bits are sent.
    localparam int CNT_W = $clog2(STOP_CYCLES);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CYCLES - 1);
    localparam logic [3:0]       IDX_LAST  = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
    logic [3:0]       data_idx_reg, data_idx_next;
    logic [7:0]       data_reg, data_next;
    logic [9:0]       sym;

    function automatic logic [4:0] enc_nibble(input logic [3:0] nib);
        logic [4:0] s;
        case (nib)
            4'h0: s = 5'b11110;
            4'h1: s = 5'b01001;
            4'h2: s = 5'b10100;
            4'h3: s = 5'b10101;
            4'h4: s = 5'b01010;
            4'h5: s = 5'b01011;
            4'h6: s = 5'b01110;
            4'h7: s = 5'b01111;
            4'h8: s = 5'b10010;
            4'h9: s = 5'b10011;
            4'hA: s = 5'b10110;
            4'hB: s = 5'b10111;
            4'hC: s = 5'b11010;
            4'hD: s = 5'b11011;
            4'hE: s = 5'b11100;
            default: s = 5'b11101;
        endcase
        return s;
    endfunction

    // Low nibble symbol occupies sym[4:0], so indexing sym by data_idx sends low symbol first, each LSB first.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sym
            assign sym[gi*5 +: 5] = enc_nibble(data_reg[gi*4 +: 4]);
        end
    endgenerate

    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= '0;
            data_idx_reg <= '0;
            data_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            data_idx_reg <= data_idx_next;
            data_reg     <= data_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        data_idx_next = data_idx_reg;
        data_next     = data_reg;
        tx_ready      = 1'b0;
        TXD           = 1'b1;
        frame_done    = 1'b0;

        case (state_reg)
            IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    data_next     = tx_data;
                    state_next    = START;
                    bit_cnt_next  = '0;
                    data_idx_next = '0;
                end
            end
            START: begin
                TXD = 1'b0;
                if (bit_cnt_reg == BIT_LAST) begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
                end else begin
                    bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                end
            end
            DATA: begin
                TXD = sym[data_idx_reg];
                if (bit_cnt_reg == BIT_LAST) begin
                    bit_cnt_next = '0;
                    if (data_idx_reg == IDX_LAST) begin
                        state_next    = STOP;
                        data_idx_next = '0;
                    end else begin
                        data_idx_next = data_idx_reg + 4'd1;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_cnt_reg == STOP_LAST) begin
                    frame_done   = 1'b1;
                    state_next   = IDLE;
                    bit_cnt_next = '0;
                end else begin
                    bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next    = IDLE;
                bit_cnt_next  = '0;
                data_idx_next = '0;
            end
        endcase
    end

    assign busy = ~tx_ready;

endmodule

// File: tb/tb_enc_4b5b_tx.sv
// Directed bench for enc_4b5b_tx: frame bit patterns, frame_done timing, back-to-back, mid-frame reset.
// Follows ENC_4B5B_TX_STOP2_EN when it is defined for the whole build.
module tb_enc_4b5b_tx;

    localparam int BC = 45;
`ifdef ENC_4B5B_TX_STOP2_EN
    localparam int NBITS = 13;
`else
    localparam int NBITS = 12;
`endif
    localparam int FRAME_CYC = NBITS * BC;

    logic       CLK_50M = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, TXD, busy, frame_done;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0]  data;
        logic [11:0] bits;   // line bits in send order, first bit in bit 11
    } vec_t;

    vec_t vecs[10];

    enc_4b5b_tx #(.BIT_CYCLES(BC)) dut (
        .CLK_50M    (CLK_50M),
        .RST        (RST),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .TXD        (TXD),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #10 CLK_50M = ~CLK_50M;

    function automatic logic [3:0] dec5(input logic [4:0] s);
        logic [3:0] n;
        case (s)
            5'b11110: n = 4'h0;  5'b01001: n = 4'h1;  5'b10100: n = 4'h2;  5'b10101: n = 4'h3;
            5'b01010: n = 4'h4;  5'b01011: n = 4'h5;  5'b01110: n = 4'h6;  5'b01111: n = 4'h7;
            5'b10010: n = 4'h8;  5'b10011: n = 4'h9;  5'b10110: n = 4'hA;  5'b10111: n = 4'hB;
            5'b11010: n = 4'hC;  5'b11011: n = 4'hD;  5'b11100: n = 4'hE;  5'b11101: n = 4'hF;
            default:  n = 4'h0;
        endcase
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = %0h", name, act);
        end
    endtask

    // {tx_ready, busy, TXD, frame_done} must read 1,0,1,0 in idle
    task automatic idle_check(input string name);
        @(negedge CLK_50M);
        check(name, {28'd0, tx_ready, busy, TXD, frame_done}, 32'hA);
    endtask

    task automatic send(input logic [7:0] d, input bit hold);
        @(negedge CLK_50M);
        tx_data  = d;
        tx_valid = 1'b1;
        check($sformatf("0x%02h ready_at_offer", d), {31'd0, tx_ready}, 32'd1);
        @(posedge CLK_50M);
        #1;
        if (!hold) tx_valid = 1'b0;
    endtask

    // Called just after the acceptance edge; walks cycles 1..FRAME_CYC of the frame.
    task automatic check_frame(input logic [7:0] d, input logic [11:0] bits);
        logic [12:0] mid;
        logic        exp_b;
        int          ctrl_err;
        int          done_err;
        int          done_at;
        logic [7:0]  rx;
        mid      = '0;
        ctrl_err = 0;
        done_err = 0;
        done_at  = 0;
        for (int i = 0; i < NBITS; i++) begin
            int bit_err;
            bit_err = 0;
            exp_b = (i < 12) ? bits[11 - i] : 1'b1;
            for (int c = 0; c < BC; c++) begin
                int k;
                @(negedge CLK_50M);
                k = i * BC + c + 1;
                if (TXD !== exp_b) bit_err++;
                if (busy !== 1'b1 || tx_ready !== 1'b0) ctrl_err++;
                if (frame_done === 1'b1) done_at = k;
                if (frame_done !== (k == FRAME_CYC)) done_err++;
                if (c == BC / 2) mid[i] = TXD;
            end
            check($sformatf("0x%02h bit%0d_err_cycles", d, i), bit_err, 0);
        end
        check($sformatf("0x%02h busy_err_cycles", d), ctrl_err, 0);
        check($sformatf("0x%02h frame_done_err_cycles", d), done_err, 0);
        check($sformatf("0x%02h frame_done_cycle", d), done_at, FRAME_CYC);
        rx = {dec5({mid[10], mid[9], mid[8], mid[7], mid[6]}),
              dec5({mid[5], mid[4], mid[3], mid[2], mid[1]})};
        check($sformatf("0x%02h loopback", d), {24'd0, rx}, {24'd0, d});
    endtask

    initial begin
        int err;

        vecs[0] = '{8'h00, 12'b0011_1101_1111};
        vecs[1] = '{8'hA5, 12'b0110_1001_1011};
        vecs[2] = '{8'hFF, 12'b0101_1110_1111};
        vecs[3] = '{8'h12, 12'b0001_0110_0101};
        vecs[4] = '{8'h34, 12'b0010_1010_1011};
        vecs[5] = '{8'h3C, 12'b0010_1110_1011};
        vecs[6] = '{8'h7E, 12'b0001_1111_1101};
        vecs[7] = '{8'h89, 12'b0110_0101_0011};
        vecs[8] = '{8'hD6, 12'b0011_1011_0111};
        vecs[9] = '{8'hBB, 12'b0111_0111_1011};

        // Reset, then 100 idle cycles
        repeat (3) @(posedge CLK_50M);
        idle_check("reset_state");
        RST = 1'b0;
        err = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge CLK_50M);
            if ({tx_ready, busy, TXD, frame_done} !== 4'b1010) err++;
        end
        check("idle_100_err_cycles", err, 0);

        // Table of single frames
        for (int v = 0; v < 10; v++) begin
            send(vecs[v].data, 1'b0);
            check_frame(vecs[v].data, vecs[v].bits);
            idle_check($sformatf("0x%02h idle_after", vecs[v].data));
        end

        // tx_valid held high: 0x12 then 0x34, one idle cycle between frames
        send(8'h12, 1'b1);
        tx_data = 8'h34;
        check_frame(8'h12, vecs[3].bits);
        idle_check("b2b_gap_cycle");
        @(posedge CLK_50M);
        #1;
        tx_valid = 1'b0;
        tx_data  = 8'hEE;
        check_frame(8'h34, vecs[4].bits);
        idle_check("b2b_idle_after");

        // Reset during bit 6 of 0x00 (a low bit), with tx_valid also high
        send(8'h00, 1'b0);
        repeat (6 * BC + 9) @(negedge CLK_50M);
        check("abort_txd_before_rst", {31'd0, TXD}, 32'd0);
        RST      = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        idle_check("abort_state_next_cycle");
        idle_check("rst_beats_valid");
        RST      = 1'b0;
        tx_valid = 1'b0;
        err = 0;
        for (int c = 0; c < FRAME_CYC + 60; c++) begin
            @(negedge CLK_50M);
            if ({tx_ready, busy, TXD, frame_done} !== 4'b1010) err++;
        end
        check("abort_no_frame_err_cycles", err, 0);

        // Recovery after abort
        send(8'h3C, 1'b0);
        check_frame(8'h3C, vecs[5].bits);
        idle_check("recover_idle_after");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
